// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo back end (RS, scheduler, execution unit).
package tomasulo_pkg;

   localparam int W_WORD        = 32;
   localparam int IMM_W         = 20;
   localparam int TAG_W         = 4;
   localparam int ROBID_W       = 5;
   localparam int WA_W          = 5;
   // Issue-to-CDB latency; the RS and scheduler reserve CDB slots using the same value.
   localparam int EXE_LATENCY_N = 2;

   typedef logic [W_WORD-1:0]  word_t;
   typedef logic [IMM_W-1:0]   imm_t;
   typedef logic [TAG_W-1:0]   tag_t;
   typedef logic [ROBID_W-1:0] robid_t;
   typedef logic [WA_W-1:0]    wa_t;

   typedef enum logic [5:0] {
      ADD  = 6'd0,
      SUB  = 6'd1,
      AND  = 6'd2,
      OR   = 6'd3,
      XOR  = 6'd4,
      SLL  = 6'd5,
      SRL  = 6'd6,
      SRA  = 6'd7,
      ADDI = 6'd8,
      LUI  = 6'd9,
      SLT  = 6'd10,
      MOV  = 6'd11
   } opcode_t;

   typedef struct packed {
      opcode_t         op;
      word_t [1:0]     rdata;
      imm_t            imm;
      tag_t            tag;
      robid_t          robid;
      wa_t             wa;
   } issue_t;

   typedef struct packed {
      logic   vld;
      tag_t   tag;
      word_t  wdata;
      robid_t robid;
      wa_t    wa;
      logic   exc;
   } cdb_t;

   // Sign-extend the immediate to a full word.
   function automatic word_t sext_imm(imm_t imm);
      return {{(W_WORD-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/tomasulo_alu.sv
// Combinational integer ALU; unknown opcodes return zero and flag an exception.
module tomasulo_alu import tomasulo_pkg::*; (
   input  opcode_t op,
   input  word_t   a,
   input  word_t   b,
   input  imm_t    imm,
   output word_t   wdata,
   output logic    exc
);

   logic [4:0] sh;
   assign sh = b[4:0];

   // Opcode decode and evaluation.
   always_comb begin
      wdata = '0;
      exc   = 1'b0;
      case (op)
         ADD:     wdata = a + b;
         SUB:     wdata = a - b;
         AND:     wdata = a & b;
         OR:      wdata = a | b;
         XOR:     wdata = a ^ b;
         SLL:     wdata = a << sh;
         SRL:     wdata = a >> sh;
         SRA:     wdata = word_t'($signed(a) >>> sh);
         ADDI:    wdata = a + sext_imm(imm);
         LUI:     wdata = word_t'(imm) << (W_WORD - IMM_W);
         SLT:     wdata = word_t'($signed(a) < $signed(b));
         MOV:     wdata = a;
         default: exc   = 1'b1;
      endcase
   end

endmodule

// File: rtl/tomasulo_exe.sv
// Fixed-latency execution unit: ALU at stage 0, then a LATENCY_N-deep register pipe
// whose last stage is the CDB write. No back-pressure; flush kills everything in flight.
module tomasulo_exe import tomasulo_pkg::*; #(
   parameter int LATENCY_N = EXE_LATENCY_N,
   parameter int W         = $bits(word_t)
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   iss_vld_r,
   input  issue_t iss_r,
   input  logic   flush,
   output cdb_t   cdb_r,
   output logic   busy
);

   if (LATENCY_N < 1 || LATENCY_N > 8) begin : g_bad_latency
      $error("tomasulo_exe: LATENCY_N=%0d outside 1..8", LATENCY_N);
   end
   if (W != $bits(word_t)) begin : g_bad_width
      $error("tomasulo_exe: W=%0d does not match word_t", W);
   end

   word_t alu_wdata;
   logic  alu_exc;
   cdb_t  alu_c;
   cdb_t  stg_out [LATENCY_N];

   tomasulo_alu u_alu (
      .op    (iss_r.op),
      .a     (iss_r.rdata[0]),
      .b     (iss_r.rdata[1]),
      .imm   (iss_r.imm),
      .wdata (alu_wdata),
      .exc   (alu_exc)
   );

   // Stage 0: package the ALU result with the pass-through identifiers.
   always_comb begin
      alu_c       = '0;
      alu_c.vld   = iss_vld_r;
      alu_c.tag   = iss_r.tag;
      alu_c.wdata = alu_wdata;
      alu_c.robid = iss_r.robid;
      alu_c.wa    = iss_r.wa;
      alu_c.exc   = alu_exc;
   end

   for (genvar i = 0; i < LATENCY_N; i++) begin : g_stg
      cdb_t stg_in, stg_d, stg_q;

      if (i == 0) begin : g_src
         assign stg_in = alu_c;
      end else begin : g_src
         assign stg_in = stg_out[i-1];
      end

      // Payload only moves with a valid entry; flush drops the incoming valid.
      always_comb begin
         stg_d = stg_q;
         if (stg_in.vld) stg_d = stg_in;
         stg_d.vld = stg_in.vld & ~flush;
      end

      // Stage register; reset clears only the valid bit.
      always_ff @(posedge clk) begin
         stg_q <= stg_d;
         if (rst) stg_q.vld <= 1'b0;
      end

      assign stg_out[i] = stg_q;
   end

   assign cdb_r = stg_out[LATENCY_N-1];

   // Any live entry anywhere in the pipe, CDB stage included.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LATENCY_N; k++) busy = busy | stg_out[k].vld;
   end

   a_no_cdb_after_flush: assert property (@(posedge clk) $past(flush) |-> !cdb_r.vld)
      else $error("tomasulo_exe: CDB write in the cycle after flush");

endmodule

// File: tb/tb_tomasulo_exe.sv
// Bench for tomasulo_exe: a LATENCY_N=2 and a LATENCY_N=1 instance share stimulus.
// Expected outputs come from an issue history: an issue at cycle c appears on the CDB
// at cycle c+L unless flush or rst was high in any cycle c..c+L-1.
module tb_tomasulo_exe;
   import tomasulo_pkg::*;

   localparam int HMAX = 1024;

   logic   clk;
   logic   rst;
   logic   iss_vld_r;
   issue_t iss_r;
   logic   flush;
   cdb_t   cdb2, cdb1;
   logic   busy2, busy1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      bit     vld;
      bit     kill;
      issue_t iss;
   } rec_t;
   rec_t hist [HMAX];

   tomasulo_exe #(.LATENCY_N(2)) dut2 (
      .clk(clk), .rst(rst), .iss_vld_r(iss_vld_r), .iss_r(iss_r),
      .flush(flush), .cdb_r(cdb2), .busy(busy2)
   );

   tomasulo_exe #(.LATENCY_N(1)) dut1 (
      .clk(clk), .rst(rst), .iss_vld_r(iss_vld_r), .iss_r(iss_r),
      .flush(flush), .cdb_r(cdb1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record what each edge sampled.
   always @(posedge clk) begin
      if (cyc < HMAX) begin
         hist[cyc].vld  = iss_vld_r;
         hist[cyc].kill = flush | rst;
         hist[cyc].iss  = iss_r;
      end
      cyc = cyc + 1;
   end

   // Reference result {exc, wdata} from the opcode definitions.
   function automatic logic [32:0] ref_alu(opcode_t op, word_t a, word_t b, imm_t imm);
      int unsigned sh;
      word_t       ones;
      sh   = 32'(b[4:0]);
      ones = 32'hFFFF_FFFF;
      case (op)
         ADD:  return {1'b0, a + b};
         SUB:  return {1'b0, a - b};
         AND:  return {1'b0, a & b};
         OR:   return {1'b0, a | b};
         XOR:  return {1'b0, a ^ b};
         SLL:  return {1'b0, a << sh};
         SRL:  return {1'b0, a >> sh};
         SRA:  return {1'b0, (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)};
         ADDI: return {1'b0, a + (imm[19] ? {12'hFFF, imm} : {12'h000, imm})};
         LUI:  return {1'b0, imm, 12'h000};
         SLT:  return {1'b0, 31'h0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))};
         MOV:  return {1'b0, a};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Issue from cycle src still alive in cycle n.
   function automatic bit alive(int src, int n);
      if (src < 0 || n > HMAX) return 1'b0;
      if (!hist[src].vld) return 1'b0;
      for (int c = src; c < n; c++) if (hist[c].kill) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cmp(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s L=%0d cyc=%0d got=%0h want=%0h", nm, l, cyc, act, exp);
      end
   endtask

   task automatic check_dut(input int l, input cdb_t c, input logic b);
      bit          ev, eb;
      logic [32:0] r;
      rec_t        h;
      ev = alive(cyc - l, cyc);
      eb = 1'b0;
      for (int k = 1; k <= l; k++) if (alive(cyc - k, cyc)) eb = 1'b1;
      cmp("m_vld",  l, 32'(c.vld), 32'(ev));
      cmp("m_busy", l, 32'(b),     32'(eb));
      if (ev) begin
         h = hist[cyc - l];
         r = ref_alu(h.iss.op, h.iss.rdata[0], h.iss.rdata[1], h.iss.imm);
         cmp("m_wdata", l, c.wdata,     r[31:0]);
         cmp("m_exc",   l, 32'(c.exc),   32'(r[32]));
         cmp("m_tag",   l, 32'(c.tag),   32'(h.iss.tag));
         cmp("m_robid", l, 32'(c.robid), 32'(h.iss.robid));
         cmp("m_wa",    l, 32'(c.wa),    32'(h.iss.wa));
      end
   endtask

   // Compare both instances against the model every cycle after the first edge.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < HMAX) begin
         check_dut(2, cdb2, busy2);
         check_dut(1, cdb1, busy1);
      end
   end

   task automatic drive(input bit v, input opcode_t op, input word_t a, input word_t b,
                        input imm_t imm, input tag_t tg, input robid_t rid, input bit fl, input bit r);
      @(negedge clk);
      iss_vld_r      = v;
      iss_r.op       = op;
      iss_r.rdata[0] = a;
      iss_r.rdata[1] = b;
      iss_r.imm      = imm;
      iss_r.tag      = tg;
      iss_r.robid    = rid;
      iss_r.wa       = wa_t'(rid ^ 5'h1F);
      flush          = fl;
      rst            = r;
   endtask

   task automatic idle();
      drive(1'b0, MOV, 32'h0, 32'h0, 20'h0, 4'h0, 5'h0, 1'b0, 1'b0);
   endtask

   task automatic iss(input opcode_t op, input word_t a, input word_t b, input imm_t imm,
                      input tag_t tg, input robid_t rid);
      drive(1'b1, op, a, b, imm, tg, rid, 1'b0, 1'b0);
   endtask

   opcode_t tv_op [10] = '{AND, OR, SLL, SRL, LUI, SLT, SRA, XOR, ADDI, MOV};
   word_t   tv_a  [10] = '{32'hF0F0_1234, 32'h0F00_0001, 32'h0000_0003, 32'h8000_0010,
                           32'h0, 32'h0000_0005, 32'h7FFF_FFF0, 32'hAAAA_5555,
                           32'h0000_0100, 32'hCAFE_F00D};
   word_t   tv_b  [10] = '{32'h0FF0_FF00, 32'h00F0_0100, 32'h0000_0021, 32'h0000_0004,
                           32'h0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_0000,
                           32'h0, 32'h0};
   imm_t    tv_imm[10] = '{20'h0, 20'h0, 20'h0, 20'h0, 20'hABCDE, 20'h0, 20'h0, 20'h0,
                           20'h7FFFF, 20'h0};

   initial begin
      iss_vld_r = 1'b0;
      iss_r     = '0;
      flush     = 1'b0;
      rst       = 1'b1;

      // Reset, then a quiet stretch.
      repeat (3) drive(1'b0, MOV, 32'h0, 32'h0, 20'h0, 4'h0, 5'h0, 1'b0, 1'b1);
      repeat (10) begin
         idle();
         cmp("idle_vld",  2, 32'(cdb2.vld), 32'h0);
         cmp("idle_busy", 2, 32'(busy2),    32'h0);
      end

      // Single ADD with wrap-around.
      iss(ADD, 32'hFFFF_FFFF, 32'h2, 20'h0, 4'd3, 5'd5);
      idle();
      idle();
      cmp("add_vld",   2, 32'(cdb2.vld),   32'h1);
      cmp("add_wdata", 2, cdb2.wdata,      32'h0000_0001);
      cmp("add_tag",   2, 32'(cdb2.tag),   32'h3);
      cmp("add_robid", 2, 32'(cdb2.robid), 32'h5);
      cmp("add_exc",   2, 32'(cdb2.exc),   32'h0);
      idle();
      cmp("add_once",  2, 32'(cdb2.vld),   32'h0);

      // Back-to-back issues drain in order.
      iss(SUB, 32'd5, 32'd7, 20'h0, 4'd1, 5'd10);
      iss(SRA, 32'h8000_0000, 32'd4, 20'h0, 4'd2, 5'd11);
      iss(SLT, 32'hFFFF_FFFF, 32'd1, 20'h0, 4'd4, 5'd12);
      cmp("b2b_sub", 2, cdb2.wdata, 32'hFFFF_FFFE);
      idle();
      cmp("b2b_sra", 2, cdb2.wdata, 32'hF800_0000);
      idle();
      cmp("b2b_slt", 2, cdb2.wdata, 32'h0000_0001);
      cmp("b2b_vld", 2, 32'(cdb2.vld), 32'h1);
      idle();

      // Flush kills the XOR in flight and the ADD issued alongside it.
      iss(XOR, 32'h1234_5678, 32'hFFFF_0000, 20'h0, 4'd6, 5'd1);
      drive(1'b1, ADD, 32'd1, 32'd1, 20'h0, 4'd8, 5'd2, 1'b1, 1'b0);
      idle();
      cmp("fl_vld_c2",  2, 32'(cdb2.vld), 32'h0);
      cmp("fl_busy_c2", 2, 32'(busy2),    32'h0);
      idle();
      cmp("fl_vld_c3",  2, 32'(cdb2.vld), 32'h0);
      cmp("fl_busy_c3", 2, 32'(busy2),    32'h0);

      // Issue right after flush completes normally.
      drive(1'b0, MOV, 32'h0, 32'h0, 20'h0, 4'h0, 5'h0, 1'b1, 1'b0);
      iss(MOV, 32'h1234_5678, 32'h0, 20'h0, 4'd9, 5'd3);
      idle();
      idle();
      cmp("post_fl_vld", 2, 32'(cdb2.vld), 32'h1);
      cmp("post_fl_wd",  2, cdb2.wdata,    32'h1234_5678);

      // Unknown opcode still writes the CDB with an exception.
      iss(opcode_t'(6'h3F), 32'hDEAD_BEEF, 32'h1, 20'h0, 4'd7, 5'd4);
      idle();
      idle();
      cmp("bad_vld",   2, 32'(cdb2.vld), 32'h1);
      cmp("bad_wdata", 2, cdb2.wdata,    32'h0);
      cmp("bad_exc",   2, 32'(cdb2.exc), 32'h1);
      cmp("bad_tag",   2, 32'(cdb2.tag), 32'h7);

      // ADDI with negative immediate; single-stage build answers next cycle.
      iss(ADDI, 32'd10, 32'h0, 20'hFFFFD, 4'd5, 5'd6);
      idle();
      cmp("addi_l1_vld", 1, 32'(cdb1.vld), 32'h1);
      cmp("addi_l1_wd",  1, cdb1.wdata,    32'h7);
      idle();
      cmp("addi_l2_wd",  2, cdb2.wdata,    32'h7);

      // Reset mid-flight kills the result.
      iss(ADD, 32'd1, 32'd1, 20'h0, 4'd2, 5'd7);
      drive(1'b0, MOV, 32'h0, 32'h0, 20'h0, 4'h0, 5'h0, 1'b0, 1'b1);
      idle();
      cmp("rst_l2_vld",  2, 32'(cdb2.vld), 32'h0);
      cmp("rst_l2_busy", 2, 32'(busy2),    32'h0);
      drive(1'b1, ADDI, 32'd10, 32'h0, 20'hFFFFD, 4'd1, 5'd8, 1'b0, 1'b1);
      idle();
      cmp("rst_l1_vld",  1, 32'(cdb1.vld), 32'h0);
      idle();

      // Remaining opcodes back to back.
      for (int i = 0; i < 10; i++) iss(tv_op[i], tv_a[i], tv_b[i], tv_imm[i], tag_t'(i), robid_t'(i + 16));
      idle();
      idle();

      // Mixed burst with gaps, bad opcodes and occasional flush.
      for (int i = 0; i < 60; i++) begin
         drive($urandom_range(0, 3) != 0, opcode_t'(6'($urandom_range(0, 13))),
               $urandom, $urandom, imm_t'($urandom), tag_t'($urandom), robid_t'($urandom),
               $urandom_range(0, 15) == 0, 1'b0);
      end
      repeat (4) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tomasulo_exe.md
# tomasulo_exe

Fixed-latency integer execution unit that sits directly downstream of the reservation station. It accepts one issued instruction per cycle from `iss_vld_r`/`iss_r`, evaluates it, and carries the result down a `LATENCY_N`-deep valid/data pipe. The result is driven onto the common data bus as `cdb_t`. No back-pressure exists: the CDB slot is already reserved through the scheduler (`sch_r`) at issue time, so the unit never stalls.

## Interface
- `LATENCY_N`, default 2: issue-to-CDB latency in cycles. Legal range is 1..8 and it must equal the value given to the paired RS.
- `W`, default 32: datapath word width; equals `$bits(word_t)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `iss_vld_r`  in  1  issued-instruction valid (registered by RS).
- `iss_r`  in  `issue_t`  issued instruction: `op`, `rdata[1:0]`, `imm`, `tag`, `robid`, `wa`.
- `flush`  in  1  kill all in-flight work; it takes priority over every other event.
- `cdb_r`  out  `cdb_t`  CDB write: `vld`, `tag`, `wdata`, `robid`, `wa`, `exc`.
- `busy`  out  1  high when any pipe stage holds a valid entry.

## Operation
- Stage 0 evaluates the combinational ALU on `iss_r` when `iss_vld_r` is high.
- Stages 1..`LATENCY_N`-1 are pure delay registers that carry the valid bit and payload.
- The last stage register is `cdb_r`.
- Opcodes and results (all mod 2^W):
  - `ADD` a+b
  - `SUB` a−b
  - `AND`, `OR`, `XOR` bitwise
  - `SLL` a << b[4:0]
  - `SRL` logical a >> b[4:0]
  - `SRA` arithmetic a >> b[4:0]
  - `ADDI` a + sext(`imm`)
  - `LUI` `imm` << (W−`$bits(imm_t)`)
  - `SLT` signed a<b → 1/0
  - `MOV` a
- Operand mapping: a = `rdata[0]`, b = `rdata[1]`.
- Unrecognised opcode: `wdata` = 0 and `exc` = 1. It still writes the CDB, because the ROB must retire the slot.
- `tag`, `robid` and `wa` pass through unchanged.
- Payload registers load only when the stage's incoming valid is 1. Valid bits always load.
- `flush`: all valid bits, including `cdb_r.vld`, clear at the next edge. An `iss_vld_r` arriving in the same cycle as `flush` is discarded.
- `busy` is the OR of all stage valid bits, including `cdb_r.vld`.

## Timing
- An issue valid at edge t produces `cdb_r.vld`=1 during cycle t+`LATENCY_N`, where cycle t is the one in which `iss_vld_r` is sampled high. The result is held for exactly one cycle.
- Throughput is 1 per cycle. Back-to-back issues produce back-to-back CDB writes in issue order. The pipe cannot reorder.
- Reset values: `cdb_r.vld`=0, all stage valids=0, `busy`=0.
- Payload fields are don't-care after reset. The bench must check them only when `vld`=1.
- `LATENCY_N`=1: no delay stages; ALU output registers straight into `cdb_r`.
- Reset asserted mid-flight behaves like `flush`: no CDB write is produced for the killed instructions.
- Deasserting `flush` in cycle t+1 allows a fresh issue in cycle t+1 to complete normally.
- Illegal `LATENCY_N` triggers an elaboration-time assertion.
- Runtime assertion: `cdb_r.vld` must never be 1 while `flush` was high on the previous edge.

## Structure
- `tomasulo_pkg` additions:
  - `opcode_t` enum values `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLL`, `SRL`, `SRA`, `ADDI`, `LUI`, `SLT`, `MOV`.
  - An `exc` bit in `cdb_t`.
  - A `sext_imm()` function.
- The `LATENCY_N` default lives as a package constant shared with the RS and the scheduler.
- One sub-module, `tomasulo_alu`: purely combinational (`op`, a, b, `imm`) → (`wdata`, `exc`).
- The delay pipe is a generate loop inside `tomasulo_exe`.

## Test plan
- Reset, then idle for 10 cycles → `cdb_r.vld`=0 and `busy`=0 throughout.
- `ADD` with a=0xFFFF_FFFF, b=2, tag=3, robid=5 at cycle 0 → cycle 2: `vld`=1, `wdata`=0x0000_0001, tag=3, robid=5, `exc`=0; cycle 3: `vld`=0.
- Back-to-back `SUB` 5−7, `SRA` 0x8000_0000>>4, `SLT` −1<1 on cycles 0, 1, 2 → cycles 2, 3, 4 carry 0xFFFF_FFFE, 0xF800_0000, 1, in order.
- Issue `XOR` at cycle 0, `flush` at cycle 1 with a simultaneous `ADD` → no CDB write at cycles 2 or 3, and `busy`=0 from cycle 2.
- Undefined opcode 0x3F, tag=7 → cycle 2: `vld`=1, `wdata`=0, `exc`=1, tag=7.
- `LATENCY_N`=1 build with `ADDI` a=10, imm=−3 → next cycle `wdata`=7; `rst` asserted while a result is in flight → no CDB write.
